// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared state encoding and helpers for the serial multiplier and divider
package serial_arith_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  function automatic int step_cnt_w(input int width);
    return $clog2(2 * width + 1);
  endfunction
  // Caller sign-extends to 64 bits; the most negative value maps to its unsigned magnitude
  function automatic logic [63:0] mag(input logic [63:0] v);
    return v[63] ? -v : v;
  endfunction
endpackage

// File: rtl/div_sub_step.sv
// div_sub_step: one restoring-division trial subtract a-b on a Kogge-Stone prefix carry tree
// diff drops the top bit: whenever there is no borrow the result is below |B| and fits in N-1 bits.
module div_sub_step #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-2:0] diff,
  output logic         borrow
);
  logic [N-1:0] pa;
  logic [N:0] g, p, t;
  assign pa = a ^ ~b;
  // Position 0 carries the +1 carry-in of the two's-complement subtract
  always_comb begin
    g = {a & ~b, 1'b1};
    p = {pa, 1'b0};
    t = g;
    for (int d = 1; d <= N; d = d * 2) begin
      t = g;
      for (int i = d; i <= N; i++) t[i] = g[i] | (p[i] & g[i-d]);
      for (int i = N; i >= d; i--) p[i] = p[i] & p[i-d];
      g = t;
    end
  end
  assign diff = pa[N-2:0] ^ g[N-2:0];
  assign borrow = ~g[N];
endmodule

// File: rtl/signed_serial_divider_16_8.sv
// signed_serial_divider_16_8: 2w/w signed restoring divider, one quotient bit per clock
// Define SIGNED_SERIAL_DIV_DBZ_EN to short-circuit B=0 into a one-cycle divide-by-zero result.
module signed_serial_divider_16_8
  import serial_arith_pkg::*;
#(
  parameter int width = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [2*width-1:0]   A,
  input  logic [width-1:0]     B,
  output logic                 valid,
  output logic [2*width-1:0]   Q,
  output logic [width-1:0]     R,
  output logic                 dz
);
  localparam int W2 = 2 * width;
  localparam int W1 = width + 1;
  localparam int CW = step_cnt_w(width);
  state_t state, next;
  logic start, last, dz_b, dz_pend, sign_q, sign_r, borrow;
  logic [W2-1:0] dvd;
  logic [width:0] bmag, trial;
  logic [width-1:0] pr, diff;
  logic [CW-1:0] cnt;
  assign start = en && (state == IDLE || state == DONE);
  assign last = cnt == CW'(W2 - 1);
  assign trial = {pr, dvd[W2-1]};
  div_sub_step #(.N(W1)) u_sub (.a(trial), .b(bmag), .diff(diff), .borrow(borrow));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = start ? (dz_b ? FIX : CALC) : (state == CALC && last) ? FIX : (state == FIX) ? DONE : state;
  end
  // dvd shifts dividend bits out of the top while quotient bits enter at the bottom
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid <= 1'b0;
      Q <= '0;
      R <= '0;
      dvd <= '0;
      bmag <= '0;
      pr <= '0;
      cnt <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (start) begin
      sign_q <= A[W2-1] ^ B[width-1];
      sign_r <= A[W2-1];
      dvd <= W2'(mag(64'($signed(A))));
      bmag <= W1'(mag(64'($signed(B))));
      pr <= '0;
      cnt <= '0;
      valid <= 1'b0;
    end else if (state == CALC) begin
      pr <= borrow ? trial[width-1:0] : diff;
      dvd <= {dvd[W2-2:0], ~borrow};
      cnt <= cnt + 1'b1;
    end else if (state == FIX) begin
      Q <= dz_pend ? '1 : sign_q ? -dvd : dvd;
      R <= dz_pend ? '0 : sign_r ? -pr : pr;
      valid <= 1'b1;
    end
`ifdef SIGNED_SERIAL_DIV_DBZ_EN
  assign dz_b = B == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dz <= 1'b0;
      dz_pend <= 1'b0;
    end else if (start) begin
      dz <= 1'b0;
      dz_pend <= dz_b;
    end else if (state == FIX) begin
      dz <= dz_pend;
    end
`else
  assign dz_b = 1'b0;
  assign dz_pend = 1'b0;
  assign dz = 1'b0;
`endif
endmodule
